// File: rtl/jpeg_enc_pkg.sv
// rtl/jpeg_enc_pkg.sv - shared JPEG encoder widths, limits and component enum
package jpeg_enc_pkg;
   localparam int DC_W     = 12;
   localparam int SSSS_W   = 4;
   localparam int AMP_W    = 11;
   localparam int DIFF_MAX = 2047;

   typedef enum logic [1:0] {
      Y  = 2'd0,
      CB = 2'd1,
      CR = 2'd2
   } comp_t;
endpackage

// File: rtl/dc_cat.sv
// rtl/dc_cat.sv - DC category (bit length of |diff|) and right-aligned amplitude bits
module dc_cat
   import jpeg_enc_pkg::*;
(
   input  logic signed [AMP_W:0]    diff,
   output logic [SSSS_W-1:0]        ssss,
   output logic [AMP_W-1:0]         amp
);
   logic [AMP_W-1:0] mag;
   logic [AMP_W-1:0] val;
   logic [AMP_W-1:0] mask;

   always_comb begin
      // diff is already clamped to +/-DIFF_MAX, so |diff| always fits AMP_W bits
      mag  = AMP_W'(diff[AMP_W] ? -diff : diff);
      val  = AMP_W'(diff[AMP_W] ? diff - (AMP_W+1)'(1) : diff);
      ssss = '0;
      for (int i = 0; i < AMP_W; i++) begin
         if (mag[i]) ssss = SSSS_W'(i + 1);
      end
      mask = AMP_W'((1 << ssss) - 1);
      amp  = val & mask;
   end
endmodule

// File: rtl/dc_diff_enc.sv
// rtl/dc_diff_enc.sv - two-stage DC differential encoder with per-component predictors
// Optional block counter output blk_cnt enabled by DC_DIFF_ENC_CNT_EN.
module dc_diff_enc #(
   parameter int DC_W  = jpeg_enc_pkg::DC_W,
   parameter int NCOMP = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [DC_W-1:0]     dc_in,
   input  logic [1:0]          comp_id,
   input  logic                restart,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          ssss,
   output logic [10:0]         amp,
   output logic                sat_err
`ifdef DC_DIFF_ENC_CNT_EN
   ,
   output logic [15:0]         blk_cnt
`endif
);
   import jpeg_enc_pkg::*;

   localparam int DIFF_W = AMP_W + 1;

   logic signed [DC_W-1:0]   pred [NCOMP];
   logic signed [DC_W-1:0]   pred_sel;
   logic signed [DC_W:0]     diff_full;
   logic signed [DIFF_W-1:0] diff_cl;
   logic signed [DIFF_W-1:0] s1_diff;
   logic                     clamp;
   logic                     cid_ok;
   logic                     s1_valid;
   logic                     s2_valid;
   logic                     s1_adv;
   logic                     s1_load;
   logic                     accept;
   logic [SSSS_W-1:0]        cat_ssss;
   logic [AMP_W-1:0]         cat_amp;

   always_comb begin
      cid_ok   = int'(comp_id) < NCOMP;
      s1_adv   = !s2_valid || out_ready;
      s1_load  = !s1_valid || s1_adv;
      in_ready = !(in_valid && !cid_ok) && s1_load;
      accept   = in_valid && in_ready;
      // restart takes effect ahead of a same-cycle accept
      pred_sel = '0;
      for (int i = 0; i < NCOMP; i++) begin
         if (int'(comp_id) == i && !restart) pred_sel = pred[i];
      end
      diff_full = {dc_in[DC_W-1], dc_in} - {pred_sel[DC_W-1], pred_sel};
      clamp     = 1'b1;
      if (int'(diff_full) > DIFF_MAX)
         diff_cl = DIFF_W'(DIFF_MAX);
      else if (int'(diff_full) < -DIFF_MAX)
         diff_cl = DIFF_W'(-DIFF_MAX);
      else begin
         diff_cl = DIFF_W'(diff_full);
         clamp   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NCOMP; i++) pred[i] <= '0;
         sat_err  <= 1'b0;
         s1_valid <= 1'b0;
         s1_diff  <= '0;
      end else begin
         for (int i = 0; i < NCOMP; i++) begin
            if (restart) pred[i] <= '0;
            if (accept && int'(comp_id) == i) pred[i] <= dc_in;
         end
         if (restart) sat_err <= 1'b0;
         if (accept && clamp) sat_err <= 1'b1;
         if (s1_load) begin
            s1_valid <= accept;
            if (accept) s1_diff <= diff_cl;
         end
      end
   end

   dc_cat u_cat (
      .diff (s1_diff),
      .ssss (cat_ssss),
      .amp  (cat_amp)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         ssss     <= '0;
         amp      <= '0;
      end else if (s1_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            ssss <= cat_ssss;
            amp  <= cat_amp;
         end
      end
   end

   assign out_valid = s2_valid;

`ifdef DC_DIFF_ENC_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         blk_cnt <= '0;
      else if (restart)
         blk_cnt <= '0;
      else if (s2_valid && out_ready)
         blk_cnt <= blk_cnt + 16'd1;
   end
`endif
endmodule

// File: tb/tb_dc_diff_enc.sv
// tb/tb_dc_diff_enc.sv - directed and randomized checks of dc_diff_enc against a category model
module tb_dc_diff_enc;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [11:0] dc_in = '0;
   logic [1:0]  comp_id = '0;
   logic        restart = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  ssss;
   logic [10:0] amp;
   logic        sat_err;

   int nvec = 0;
   int nerr = 0;
   int pred [3] = '{0, 0, 0};
   int exp_ss [$];
   int exp_amp [$];
   bit exp_sat = 1'b0;
   bit acc = 1'b0;

   always #5 clk = ~clk;

   dc_diff_enc #(.DC_W(12), .NCOMP(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dc_in     (dc_in),
      .comp_id   (comp_id),
      .restart   (restart),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .ssss      (ssss),
      .amp       (amp),
      .sat_err   (sat_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: clamp the difference, category = bit length, negative amp = diff + 2^ssss - 1
   task automatic model_accept();
      int dc, c, d, m, ss, a;
      dc = int'($signed(dc_in));
      c  = int'(comp_id);
      d  = dc - pred[c];
      if (d > 2047) begin d = 2047; exp_sat = 1'b1; end
      if (d < -2047) begin d = -2047; exp_sat = 1'b1; end
      m  = (d < 0) ? -d : d;
      ss = 0;
      while ((1 << ss) <= m) ss++;
      a  = (d > 0) ? d : ((d == 0) ? 0 : d + (1 << ss) - 1);
      exp_ss.push_back(ss);
      exp_amp.push_back(a);
      pred[c] = dc;
   endtask

   task automatic step();
      @(negedge clk);
      chk("sat_err", sat_err, exp_sat);
      if (in_valid && comp_id == 2'd3) chk("in_ready_bad_comp", in_ready, 0);
      if (out_valid) begin
         if (exp_ss.size() == 0) chk("spurious_out_valid", out_valid, 0);
         else begin
            chk("ssss", ssss, exp_ss[0]);
            chk("amp", amp, exp_amp[0]);
            if (out_ready) begin
               void'(exp_ss.pop_front());
               void'(exp_amp.pop_front());
            end
         end
      end
      acc = in_valid && in_ready;
      if (restart) begin
         pred = '{0, 0, 0};
         exp_sat = 1'b0;
      end
      if (acc) model_accept();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int dc, input int c, input bit rs);
      int n;
      in_valid = 1'b1;
      dc_in    = 12'(dc);
      comp_id  = 2'(c);
      restart  = rs;
      step();
      restart  = 1'b0;
      n = 0;
      while (!acc && n < 20) begin
         step();
         n++;
      end
      if (!acc) chk("send_accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_ssss", ssss, 0);
      chk("rst_amp", amp, 0);
      chk("rst_sat_err", sat_err, 0);
      rst_n = 1'b1;
      chk("rst_in_ready", in_ready, 1);

      send(100, 0, 0);
      send(90, 0, 0);
      idle(3);

      send(50, 0, 0);
      send(20, 1, 0);
      chk("b2b_valid_1", out_valid, 1);
      send(50, 0, 0);
      chk("b2b_valid_2", out_valid, 1);
      step();
      chk("b2b_valid_3", out_valid, 1);
      step();
      chk("b2b_idle", out_valid, 0);

      send(-2048, 0, 1);
      chk("sat_after_clamp", sat_err, 1);
      send(2047, 0, 0);
      idle(3);

      out_ready = 1'b0;
      in_valid  = 1'b1;
      comp_id   = 2'd0;
      dc_in     = 12'($urandom_range(0, 4095));
      for (int i = 0; i < 5; i++) begin
         step();
         if (acc) dc_in = 12'($urandom_range(0, 4095));
      end
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
      chk("stall_buffered", exp_ss.size(), 2);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(4);
      chk("stall_drain", exp_ss.size(), 0);

      send(100, 0, 0);
      send(30, 0, 1);
      idle(3);

      send(7, 0, 0);
      step();
      chk("pre_rst_out_valid", out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", out_valid, 0);
      exp_ss.delete();
      exp_amp.delete();
      pred = '{0, 0, 0};
      exp_sat = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("post_rst_in_ready", in_ready, 1);
      send(5, 0, 0);
      idle(3);

      for (int i = 0; i < 400; i++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         comp_id   = 2'($urandom_range(0, 3));
         dc_in     = 12'($urandom_range(0, 4095));
         out_ready = ($urandom_range(0, 3) != 0);
         restart   = ($urandom_range(0, 31) == 0);
         step();
      end
      in_valid  = 1'b0;
      restart   = 1'b0;
      out_ready = 1'b1;
      n = 0;
      while (exp_ss.size() > 0 && n < 20) begin
         step();
         n++;
      end
      chk("final_drain", exp_ss.size(), 0);
      step();
      chk("final_idle", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/dc_diff_enc.md
DC_DIFF_ENC -- requirements
Module: dc_diff_enc

Interface
REQ-001 SHALL have parameter DC_W, default 12, which sets the width of the signed quantized DC input.
REQ-002 SHALL have parameter NCOMP, default 3, which sets the number of colour components and predictors.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state SHALL be on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: input sample valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a sample.
REQ-007 SHALL have port dc_in, input, DC_W bits: signed quantized DC coefficient of one 8x8 block.
REQ-008 SHALL have port comp_id, input, 2 bits: component index, 0..NCOMP-1.
REQ-009 SHALL have port restart, input, 1 bit: single-cycle pulse that clears all predictors.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port ssss, output, 4 bits: DC category, used directly as the DC Huffman LUT index.
REQ-013 SHALL have port amp, output, 11 bits: amplitude bits, right-aligned, with bits at ssss and above set to 0.
REQ-014 SHALL have port sat_err, output, 1 bit: sticky flag that a difference was clamped.

Function
REQ-015 SHALL accept a sample when in_valid && in_ready; diff = dc_in - pred[comp_id], computed at DC_W+1 bits.
REQ-016 SHALL clamp diff to [-2047, +2047] and set sat_err in the cycle after any clamp.
REQ-017 SHALL load pred[comp_id] with the raw dc_in, not the clamped value, on every accept.
REQ-018 SHALL set ssss=0 for diff=0; otherwise ssss SHALL be the bit-length of |diff| (1..11).
REQ-019 SHALL set amp to the low ssss bits of diff when diff>0, and to the low ssss bits of diff-1 (one's complement) when diff<0.
REQ-020 SHALL be a two-stage pipeline: S1 computes diff and updates the predictor; S2 registers ssss and amp; latency from accept to out_valid SHALL be 2 cycles.
REQ-021 SHALL drive in_ready = !S1_valid || S1 advancing; S1 SHALL advance when !S2_valid || out_ready.
REQ-022 SHALL sustain full throughput of 1 sample/cycle with out_ready held high.
REQ-023 SHALL hold out_valid, ssss and amp stable while out_valid && !out_ready.
REQ-024 SHALL apply restart before any same-cycle accept, so that sample sees pred=0; restart SHALL also clear sat_err.
REQ-025 SHALL NOT alter samples already in S1 or S2 on restart.
REQ-026 SHALL ignore in_valid when comp_id >= NCOMP: no accept, and in_ready low for that cycle.

Reset
REQ-027 SHALL, while rst_n=0: clear all predictors to 0; set S1_valid, S2_valid, out_valid and sat_err to 0; set ssss and amp to 0.
REQ-028 SHALL discard in-flight data on reset mid-operation; in_ready SHALL be 1 in the first cycle after release.

Configuration
REQ-029 SHALL, when DC_DIFF_ENC_CNT_EN is defined, provide output blk_cnt[15:0], reset to 0, incremented on every output handshake, wrapping 0xFFFF->0, and cleared by restart.
REQ-030 SHALL, when DC_DIFF_ENC_CNT_EN is undefined, have neither the port blk_cnt nor the counter logic; all other behaviour SHALL be identical.

Structure
REQ-031 SHALL take the following from shared package jpeg_enc_pkg: DC_W, SSSS_W=4, AMP_W=11, DIFF_MAX=2047, and typedef comp_t (Y=0, CB=1, CR=2).
REQ-032 SHALL put the category/amplitude logic in one combinational sub-module, dc_cat (diff in; ssss and amp out), instantiated in S2.

Verification
REQ-033 SHALL verify: comp 0 with dc 100 then 90 -> ssss=7/amp=1100100, then ssss=4/amp=0101.
REQ-034 SHALL verify: Y=50, Cb=20, Y=50 back-to-back -> ssss 6, 5, 0; out_valid for 3 consecutive cycles.
REQ-035 SHALL verify: Y=-2048 (pred 0) then Y=2047 -> ssss=11/amp=0 (clamped), then ssss=11/amp=0x7FF; sat_err=1 after the first.
REQ-036 SHALL verify: out_ready low for 5 cycles with continuous input -> 2 samples buffered, in_ready=0, outputs stable, no loss or duplication after release.
REQ-037 SHALL verify: restart in the same cycle as accept of Y=30 (pred was 100) -> ssss=5, amp=11110 (diff +30).
REQ-038 SHALL verify: rst_n pulsed low while out_valid=1 -> out_valid=0 immediately, and the next Y=5 gives ssss=3.
